mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle main control unit for the MIPS core.
- Sits directly upstream of the datapath (PC, i/d memory, regfile, ula_control/ula, muxes). Decodes the instruction opcode held in the instruction register (IR) and sequences the datapath through fetch/decode/execute/memory/writeback steps.
- Replaces hard-wired per-instruction control signals with a Moore FSM.
- Memory accesses use a ready handshake so wait-state memories can be attached.

Parameters:
- OPC_W, 6, opcode field width (instruction[31:26])
- ALUOP_W, 2, width of ula_operation fed to ula_control (00 add, 01 sub, 10 funct)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; FSM to FETCH
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ula_zero_flag (beq)
- IorD  output  1  memory address mux: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  regfile write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  write register: 0 = rt, 1 = rd
- RegWrite  output  1  regfile write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = signext, 11 = signext<<2
- ALUOp  output  2  to ula_control
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state_o  output  4  current state encoding, for debug

Behaviour:
- State register: 4 bits. Asynchronous reset to FETCH. No other registered outputs; all outputs decode from state and mem_ready.
- While reset is high, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite and illegal_op are forced to 0.
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- FETCH (0):
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE (1):
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - Next state by opcode: lw/sw → MEMADR; R → EXEC; beq → BRANCH; addi → ADDI_EX; j → JUMP.
  - Any other opcode: illegal_op = 1 this cycle, next state FETCH, no write enables asserted.
- MEMADR (2):
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
  - Next state: lw → MEMRD, sw → MEMWR.
- MEMRD (3): MemRead = 1, IorD = 1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0. Next state FETCH.
- MEMWR (5):
  - MemWrite = 1, IorD = 1, held while waiting.
  - On mem_ready = 1 go to FETCH; the write counts exactly once, on the mem_ready cycle.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state RWB.
- RWB (7): RegWrite = 1, RegDst = 1, MemtoReg = 0. Next state FETCH.
- BRANCH (8):
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - Next state FETCH.
- ADDI_EX (9): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state ADDI_WB.
- ADDI_WB (10): RegWrite = 1, RegDst = 0, MemtoReg = 0. Next state FETCH.
- JUMP (11): PCWrite = 1, PCSource = 10. Next state FETCH.
- Unused encodings 12–15: next state FETCH, all enables 0.
- Default for any output not listed in a state: 0.
- Latency in cycles, zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait state adds 1 cycle in FETCH/MEMRD/MEMWR.
- Reset mid-instruction: immediate return to FETCH. No partial writeback; RegWrite/MemWrite drop asynchronously with reset.
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.

Optional Feature:
- Macro: MIPS_MC_CTRL_PERF_EN.
- Defined: adds outputs instret (32 bits) and cycles (32 bits).
  - Both clear on reset.
  - cycles increments every clock while reset is low.
  - instret increments on each transition into FETCH from MEMWB, MEMWR (with mem_ready), RWB, BRANCH, ADDI_WB or JUMP. The illegal-opcode DECODE→FETCH transition does not count.
  - Both wrap 0xFFFFFFFF → 0.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: reset high 3 cycles, mem_ready = 1.
  - Required: state_o = 0 and all write enables 0 during reset.
  - Required: first cycle after release, MemRead = 1, IRWrite = 1, PCWrite = 1.
- R-type:
  - Stimulus: opcode = 000000, mem_ready = 1.
  - Required: state sequence 0, 1, 6, 7, 0.
  - Required: in state 7, RegWrite = 1 and RegDst = 1; in state 6, ALUOp = 10.
- lw with wait states:
  - Stimulus: opcode = 100011; mem_ready low for 2 cycles in FETCH and for 3 cycles in MEMRD.
  - Required: sequence 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0 (11 cycles).
  - Required: IRWrite asserted only on the final FETCH cycle.
- sw and beq:
  - sw: MemWrite = 1 for the whole MEMWR residency.
  - beq (000100): exactly one cycle with PCWriteCond = 1, ALUOp = 01, PCSource = 01; returns to FETCH after 3 cycles.
- Illegal opcode and jump:
  - Stimulus: opcode = 111111.
  - Required: illegal_op pulses in DECODE, next state FETCH, no RegWrite/MemWrite.
  - Stimulus: j (000010).
  - Required: PCWrite = 1 with PCSource = 10 in state 11.
- Reset mid-instruction and counters:
  - Stimulus: assert reset during state 7.
  - Required: RegWrite falls immediately and state_o = 0.
  - With MIPS_MC_CTRL_PERF_EN, after R, lw, illegal, j: instret = 3.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multi-cycle Moore control FSM for the MIPS core; outputs decode from state and mem_ready.
// Optional perf counters (instret, cycles) when MIPS_MC_CTRL_PERF_EN is defined.
module mips_mc_control #(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
`ifdef MIPS_MC_CTRL_PERF_EN
    output logic [31:0]        instret,
    output logic [31:0]        cycles,
`endif
    output logic [3:0]         state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    state_t state_q, state_d;
    logic   pc_wr, pc_wr_cond, ir_wr, reg_wr, mem_wr, illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        illegal    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = ALU_ADD;
        PCSource   = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ir_wr   = mem_ready;
                pc_wr   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                illegal = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR, S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                reg_wr   = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                IorD   = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                reg_wr = 1'b1;
                RegDst = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_SUB;
                pc_wr_cond = 1'b1;
                PCSource   = 2'b01;
            end
            S_ADDI_WB: reg_wr = 1'b1;
            S_JUMP: begin
                pc_wr    = 1'b1;
                PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset directly so they drop without waiting for a clock.
    assign PCWrite     = pc_wr      & ~reset;
    assign PCWriteCond = pc_wr_cond & ~reset;
    assign IRWrite     = ir_wr      & ~reset;
    assign RegWrite    = reg_wr     & ~reset;
    assign MemWrite    = mem_wr     & ~reset;
    assign illegal_op  = illegal    & ~reset;
    assign state_o     = state_q;

`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] instret_q, cycles_q;
    logic        retire;

    assign retire = (state_q inside {S_MEMWB, S_RWB, S_BRANCH, S_ADDI_WB, S_JUMP}) ||
                    (state_q == S_MEMWR && mem_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for mips_mc_control; perf counters checked when MIPS_MC_CTRL_PERF_EN is defined.
module tb_mips_mc_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] instret, cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    always #5 clock = ~clock;

    mips_mc_control #(.OPC_W(6), .ALUOP_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal_op  (illegal_op),
`ifdef MIPS_MC_CTRL_PERF_EN
        .instret     (instret),
        .cycles      (cycles),
`endif
        .state_o     (state_o)
    );

    function automatic logic [5:0] wen();
        return {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, sample at the falling edge.
    task automatic step(input logic [5:0] opc, input logic mr, input logic [3:0] st, input string tag);
        @(posedge clock);
        #1;
        opcode    = opc;
        mem_ready = mr;
        @(negedge clock);
        chk(tag, {28'd0, state_o}, {28'd0, st});
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = R;
        mem_ready = 1'b1;

        repeat (3) begin
            @(negedge clock);
            chk("rst_state", {28'd0, state_o}, 32'd0);
            chk("rst_wen", {26'd0, wen()}, 32'd0);
        end

        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rel_state", {28'd0, state_o}, 32'd0);
        chk("rel_fetch", {29'd0, MemRead, IRWrite, PCWrite}, 32'b111);
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("cycles0", cycles, 32'd0);
        chk("instret0", instret, 32'd0);
`endif

        step(R, 1'b1, 4'd1, "r_dec");
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("cycles1", cycles, 32'd1);
`endif
        step(R, 1'b1, 4'd6, "r_exec");
        chk("r_aluop", {30'd0, ALUOp}, 32'b10);
        step(R, 1'b1, 4'd7, "r_wb");
        chk("r_wb_ctl", {30'd0, RegWrite, RegDst}, 32'b11);

        step(LW, 1'b0, 4'd0, "lw_f0");
        chk("lw_ir0", {31'd0, IRWrite}, 32'd0);
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("instret_r", instret, 32'd1);
`endif
        step(LW, 1'b0, 4'd0, "lw_f1");
        chk("lw_ir1", {31'd0, IRWrite}, 32'd0);
        step(LW, 1'b1, 4'd0, "lw_f2");
        chk("lw_ir2", {31'd0, IRWrite}, 32'd1);
        step(LW, 1'b1, 4'd1, "lw_dec");
        step(LW, 1'b1, 4'd2, "lw_adr");
        chk("lw_adr_ctl", {29'd0, ALUSrcA, ALUSrcB}, 32'b110);
        step(LW, 1'b0, 4'd3, "lw_rd0");
        chk("lw_rd_ctl", {30'd0, MemRead, IorD}, 32'b11);
        step(LW, 1'b0, 4'd3, "lw_rd1");
        step(LW, 1'b0, 4'd3, "lw_rd2");
        step(LW, 1'b1, 4'd3, "lw_rd3");
        step(LW, 1'b1, 4'd4, "lw_wb");
        chk("lw_wb_ctl", {29'd0, RegWrite, MemtoReg, RegDst}, 32'b110);

        step(SW, 1'b1, 4'd0, "sw_fetch");
        step(SW, 1'b1, 4'd1, "sw_dec");
        step(SW, 1'b1, 4'd2, "sw_adr");
        step(SW, 1'b0, 4'd5, "sw_wr0");
        chk("sw_mw0", {30'd0, MemWrite, IorD}, 32'b11);
        step(SW, 1'b1, 4'd5, "sw_wr1");
        chk("sw_mw1", {30'd0, MemWrite, IorD}, 32'b11);

        step(BEQ, 1'b1, 4'd0, "beq_fetch");
        chk("beq_pwc_f", {31'd0, PCWriteCond}, 32'd0);
        step(BEQ, 1'b1, 4'd1, "beq_dec");
        chk("beq_dec_srcb", {30'd0, ALUSrcB}, 32'b11);
        step(BEQ, 1'b1, 4'd8, "beq_br");
        chk("beq_ctl", {27'd0, PCWriteCond, ALUOp, PCSource}, 32'b10101);

        step(BAD, 1'b1, 4'd0, "ill_fetch");
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("instret_beq", instret, 32'd4);
`endif
        step(BAD, 1'b1, 4'd1, "ill_dec");
        chk("ill_pulse", {26'd0, wen()}, 32'b000001);

        step(J, 1'b1, 4'd0, "j_fetch");
        chk("ill_gone", {31'd0, illegal_op}, 32'd0);
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("instret_ill", instret, 32'd4);
`endif
        step(J, 1'b1, 4'd1, "j_dec");
        step(J, 1'b1, 4'd11, "j_jump");
        chk("j_ctl", {29'd0, PCWrite, PCSource}, 32'b110);

        step(R, 1'b1, 4'd0, "r2_fetch");
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("instret_j", instret, 32'd5);
`endif
        step(R, 1'b1, 4'd1, "r2_dec");
        step(BAD, 1'b1, 4'd6, "r2_exec_opc_ignored");
        step(BAD, 1'b1, 4'd7, "r2_wb");
        chk("r2_regwr", {31'd0, RegWrite}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_regwr", {31'd0, RegWrite}, 32'd0);
        chk("mid_rst_state", {28'd0, state_o}, 32'd0);
`ifdef MIPS_MC_CTRL_PERF_EN
        chk("mid_rst_instret", instret, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset     = 1'b0;
        opcode    = R;
        mem_ready = 1'b0;
        @(negedge clock);
        chk("post_rst_state", {28'd0, state_o}, 32'd0);
        chk("post_rst_fetch", {29'd0, MemRead, IRWrite, PCWrite}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
